instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default 9, word-address width of instruction memory (2**INST_ADDR_WIDTH words).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits a new fetch when high.
REQ-006 SHALL have port pc  output  32  current PC, drives instruction memory address (memory indexes pc[31:2]).
REQ-007 SHALL have port instruction  input  32  combinational read data from instruction memory for pc.
REQ-008 SHALL have port ir  output  32  latched instruction register.
REQ-009 SHALL have port ir_pc  output  32  PC of the instruction held in ir.
REQ-010 SHALL have port ir_valid  output  1  ir holds an issued, unretired instruction.
REQ-011 SHALL have port done  input  1  control unit retires the instruction in ir this cycle.
REQ-012 SHALL have port branch_taken  input  1  qualifies branch_target; sampled only with done.
REQ-013 SHALL have port branch_target  input  32  byte address of next instruction when branch_taken.
REQ-014 SHALL have port fault  output  1  sticky fetch fault (misaligned or out-of-range PC).
REQ-015 SHALL have port instret  output  32  retired-instruction count.

Function
REQ-016 SHALL implement FSM states FETCH, ISSUED, FAULT; reset state FETCH.
REQ-017 FETCH with enable=1 and pc valid: at clock edge SHALL load ir<=instruction, ir_pc<=pc, ir_valid<=1, go ISSUED (1-cycle fetch latency).
REQ-018 FETCH with enable=0: SHALL hold pc, ir, ir_valid=0; no state change.
REQ-019 pc valid SHALL mean pc[1:0]==0 and pc[31:2] < 2**INST_ADDR_WIDTH; FETCH with enable=1 and pc invalid SHALL go FAULT without loading ir.
REQ-020 ISSUED with done=0: SHALL hold pc, ir, ir_pc, ir_valid=1; branch_taken/branch_target ignored.
REQ-021 ISSUED with done=1: next_pc = branch_taken ? branch_target : pc+4 (modulo 2**32); SHALL load pc<=next_pc, ir_valid<=0, instret<=instret+1, go FETCH.
REQ-022 ISSUED with done=1 and branch_taken=1 and branch_target[1:0]!=0: SHALL go FAULT, pc unchanged, ir_valid<=0, instret still incremented.
REQ-023 Out-of-range next_pc (e.g. pc+4 past last word) SHALL be accepted into pc and flagged by REQ-019 on next FETCH.
REQ-024 done while not ISSUED SHALL be ignored (no pc, instret or state change).
REQ-025 FAULT SHALL be terminal until reset: fault=1, ir_valid=0, pc/ir/ir_pc/instret held, all inputs ignored.
REQ-026 fault SHALL be combinationally (state==FAULT).
REQ-027 instret SHALL wrap 32'hFFFF_FFFF -> 0 without side effect.
REQ-028 pc SHALL be a register output; no combinational path from done/branch inputs to pc.
REQ-029 Retire-to-next-ir_valid latency SHALL be 2 cycles with enable=1 (done edge, then fetch edge).

Reset
REQ-030 reset=1 SHALL immediately, independent of clk: pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, instret=0, state FETCH, fault=0.
REQ-031 reset asserted mid-ISSUED SHALL discard the held instruction with no retire count.
REQ-032 First fetch after reset release SHALL occur on first rising edge with reset=0 and enable=1.

Verification
REQ-033 Reset: pulse reset asynchronously between edges -> pc=0, ir_valid=0, fault=0, instret=0 before next edge.
REQ-034 Sequential: mem[0]=32'h00007033, mem[1]=32'h00100093, enable=1, done one cycle after each ir_valid -> ir=32'h00007033 ir_pc=0, then ir=32'h00100093 ir_pc=4, instret=2.
REQ-035 Branch: ISSUED at pc=0x30, done=1, branch_taken=1, branch_target=0x54 -> pc=0x54, next ir_pc=0x54; same with branch_taken=0 -> pc=0x34.
REQ-036 Misaligned target: ISSUED at pc=0x30, done=1, branch_taken=1, branch_target=0x56 -> fault=1, pc=0x30, ir_valid=0; further done/enable ignored until reset.
REQ-037 Range: INST_ADDR_WIDTH=9, ISSUED at pc=0x7FC, done=1, branch_taken=0 -> pc=0x800, next edge fault=1, ir unchanged.
REQ-038 Stall/ignore: enable=0 for 5 cycles -> ir_valid=0, pc constant; done=1 in FETCH -> instret unchanged; done held 0 in ISSUED for 10 cycles -> ir stable.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time from
// a combinational instruction memory into an instruction register, waits for
// the control unit to retire it, then advances to pc+4 or to a branch target.
// Misaligned or out-of-range addresses put the unit into a terminal fault
// state that only reset clears.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   enable        in   permits a new fetch in FETCH
//   pc            out  current PC (memory indexes pc[31:2])
//   instruction   in   memory read data for pc
//   ir            out  instruction register
//   ir_pc         out  PC of the instruction in ir
//   ir_valid      out  ir holds an issued, unretired instruction
//   done          in   retire the instruction in ir this cycle
//   branch_taken  in   select branch_target as next PC (sampled with done)
//   branch_target in   byte address of the branch destination
//   fault         out  sticky fetch fault
//   instret       out  retired-instruction count
module instr_fetch_unit #(
  parameter int unsigned INST_ADDR_WIDTH = 9,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fault,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    FETCH,
    ISSUED,
    FAULT
  } state_t;

  // Number of words in instruction memory, widened so 2**30 still fits.
  localparam logic [30:0] WORD_LIMIT = 31'(64'd1 << INST_ADDR_WIDTH);

  state_t      state, state_next;
  logic [31:0] pc_next, ir_next, ir_pc_next, instret_next;
  logic [31:0] seq_pc;
  logic        pc_valid;

  assign pc_valid = (pc[1:0] == 2'b00) && ({1'b0, pc[31:2]} < WORD_LIMIT);
  assign seq_pc   = branch_taken ? branch_target : pc + 32'd4;
  assign ir_valid = (state == ISSUED);
  assign fault    = (state == FAULT);

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    ir_pc_next   = ir_pc;
    instret_next = instret;
    unique case (state)
      FETCH: begin
        if (enable) begin
          if (pc_valid) begin
            ir_next    = instruction;
            ir_pc_next = pc;
            state_next = ISSUED;
          end else begin
            state_next = FAULT;
          end
        end
      end
      ISSUED: begin
        if (done) begin
          instret_next = instret + 32'd1;
          // A misaligned branch target faults immediately and leaves pc at
          // the retiring instruction; range is only checked at fetch time.
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            state_next = FAULT;
          end else begin
            pc_next    = seq_pc;
            state_next = FETCH;
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      ir_pc   <= '0;
      instret <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      ir_pc   <= ir_pc_next;
      instret <= instret_next;
    end
  end

endmodule
